// File: rtl/operand_collector_if.sv
// operand_collector_if: instruction, writeback, register-file and operand-bundle signals of the collector
interface operand_collector_if #(
    parameter int WARP_W = 4,
    parameter int REG_W  = 6,
    parameter int D_W    = 8,
    parameter int TAG_W  = 8
);
    localparam int A_W = WARP_W + REG_W;
    logic              in_valid;
    logic              in_ready;
    logic [WARP_W-1:0] in_warp;
    logic [REG_W-1:0]  in_src0;
    logic [REG_W-1:0]  in_src1;
    logic [REG_W-1:0]  in_src2;
    logic [1:0]        in_nsrc;
    logic [TAG_W-1:0]  in_tag;
    logic              wb_valid;
    logic [A_W-1:0]    wb_addr;
    logic [D_W-1:0]    wb_data;
    logic [A_W-1:0]    rf_addr_a;
    logic [A_W-1:0]    rf_addr_b;
    logic [D_W-1:0]    rf_din_a;
    logic [D_W-1:0]    rf_din_b;
    logic              rf_we_a;
    logic              rf_we_b;
    logic [D_W-1:0]    rf_dout_a;
    logic [D_W-1:0]    rf_dout_b;
    logic              out_valid;
    logic              out_ready;
    logic [D_W-1:0]    out_op0;
    logic [D_W-1:0]    out_op1;
    logic [D_W-1:0]    out_op2;
    logic [TAG_W-1:0]  out_tag;
    modport slave (
        input  in_valid, in_warp, in_src0, in_src1, in_src2, in_nsrc, in_tag,
        input  wb_valid, wb_addr, wb_data, rf_dout_a, rf_dout_b, out_ready,
        output in_ready, rf_addr_a, rf_addr_b, rf_din_a, rf_din_b, rf_we_a, rf_we_b,
        output out_valid, out_op0, out_op1, out_op2, out_tag
    );
    modport master (
        output in_valid, in_warp, in_src0, in_src1, in_src2, in_nsrc, in_tag,
        output wb_valid, wb_addr, wb_data, rf_dout_a, rf_dout_b, out_ready,
        input  in_ready, rf_addr_a, rf_addr_b, rf_din_a, rf_din_b, rf_we_a, rf_we_b,
        input  out_valid, out_op0, out_op1, out_op2, out_tag
    );
endinterface

// File: rtl/operand_collector.sv
// operand_collector: fetches up to three source operands over two register-file ports,
// with writeback owning port B whenever it is requested.
module operand_collector #(
    parameter int WARP_W = 4,
    parameter int REG_W  = 6,
    parameter int D_W    = 8,
    parameter int TAG_W  = 8
) (
    input logic clk,
    input logic rst_n,
    operand_collector_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FETCH, OUT} state_t;
    state_t                    state_q, state_d;
    logic [2:0]                mask_q, mask_d, mask_a;
    logic [WARP_W-1:0]         warp_q, warp_d;
    logic [2:0][REG_W-1:0]     src_q, src_d;
    logic [TAG_W-1:0]          tag_q, tag_d;
    logic [2:0][D_W-1:0]       op_q, op_d;
    logic [1:0]                ia, ib;
    logic                      fetch, rd_b;
    always_comb begin
        fetch = state_q == FETCH;
        ia = mask_q[0] ? 2'd0 : mask_q[1] ? 2'd1 : 2'd2;
        mask_a = mask_q & ~(3'b001 << ia);
        ib = mask_a[0] ? 2'd0 : mask_a[1] ? 2'd1 : 2'd2;
        rd_b = fetch && !bus.wb_valid && (mask_a != 3'b000);
        state_d = state_q;
        mask_d = mask_q;
        warp_d = warp_q;
        src_d = src_q;
        tag_d = tag_q;
        op_d = op_q;
        bus.in_ready = state_q == IDLE;
        bus.out_valid = state_q == OUT;
        bus.out_op0 = op_q[0];
        bus.out_op1 = op_q[1];
        bus.out_op2 = op_q[2];
        bus.out_tag = tag_q;
        bus.rf_addr_a = fetch ? {warp_q, src_q[ia]} : '0;
        bus.rf_addr_b = bus.wb_valid ? bus.wb_addr : rd_b ? {warp_q, src_q[ib]} : '0;
        bus.rf_din_b = bus.wb_valid ? bus.wb_data : '0;
        // Gated by reset so a held writeback cannot corrupt the file during reset.
        bus.rf_we_b = bus.wb_valid && rst_n;
        bus.rf_we_a = 1'b0;
        bus.rf_din_a = '0;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                warp_d = bus.in_warp;
                src_d = {bus.in_src2, bus.in_src1, bus.in_src0};
                tag_d = bus.in_tag;
                op_d = '0;
                mask_d = {bus.in_nsrc == 2'd3, bus.in_nsrc[1], bus.in_nsrc != 2'd0};
                state_d = bus.in_nsrc != 2'd0 ? FETCH : OUT;
            end
            FETCH: begin
                op_d[ia] = bus.rf_dout_a;
                mask_d = mask_a;
                if (rd_b) begin
                    op_d[ib] = bus.rf_dout_b;
                    mask_d = mask_a & ~(3'b001 << ib);
                end
                if (mask_d == 3'b000) state_d = OUT;
            end
            OUT: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mask_q <= '0;
            warp_q <= '0;
            src_q <= '0;
            tag_q <= '0;
            op_q <= '0;
        end else begin
            state_q <= state_d;
            mask_q <= mask_d;
            warp_q <= warp_d;
            src_q <= src_d;
            tag_q <= tag_d;
            op_q <= op_d;
        end
    end
endmodule

// File: tb/tb_operand_collector.sv
// tb_operand_collector: directed checks of operand_collector against a behavioural
// register file that forwards port-B writes to port-A reads.
module tb_operand_collector;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int tests = 0;
    int failed = 0;
    operand_collector_if #(.WARP_W(4), .REG_W(6), .D_W(8), .TAG_W(8)) bus ();
    operand_collector #(.WARP_W(4), .REG_W(6), .D_W(8), .TAG_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    logic [7:0] mem [1024];
    always @(posedge clk) if (bus.rf_we_b) mem[bus.rf_addr_b] <= bus.rf_din_b;
    assign bus.rf_dout_a = (bus.rf_we_b && bus.rf_addr_b == bus.rf_addr_a) ? bus.rf_din_b : mem[bus.rf_addr_a];
    assign bus.rf_dout_b = mem[bus.rf_addr_b];
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic wb_write(input logic [9:0] a, input logic [7:0] d);
        bus.wb_valid = 1'b1;
        bus.wb_addr = a;
        bus.wb_data = d;
        step();
        bus.wb_valid = 1'b0;
    endtask
    task automatic issue(input logic [3:0] w, input logic [5:0] s0, input logic [5:0] s1,
                         input logic [5:0] s2, input logic [1:0] n, input logic [7:0] t);
        bus.in_valid = 1'b1;
        bus.in_warp = w;
        bus.in_src0 = s0;
        bus.in_src1 = s1;
        bus.in_src2 = s2;
        bus.in_nsrc = n;
        bus.in_tag = t;
        step();
        bus.in_valid = 1'b0;
    endtask
    task automatic test_reset();
        bus.wb_valid = 1'b1;
        bus.wb_addr = 10'd7;
        bus.wb_data = 8'hFF;
        step();
        step();
        tests++;
        if ({bus.out_valid, bus.out_op0, bus.out_op1, bus.out_op2, bus.out_tag} !== 33'h0) begin
            failed++;
            $display("FAIL reset_outputs: got %h expected 0", {bus.out_valid, bus.out_op0, bus.out_op1, bus.out_op2, bus.out_tag});
        end
        tests++;
        if (bus.rf_we_b !== 1'b0) begin
            failed++;
            $display("FAIL reset_we_b: got %b expected 0", bus.rf_we_b);
        end
        bus.wb_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        tests++;
        if (bus.in_ready !== 1'b1) begin
            failed++;
            $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
        end
    endtask
    task automatic test_nsrc2();
        issue(4'd0, 6'd1, 6'd2, 6'd0, 2'd2, 8'h5A);
        tests++;
        if ({bus.out_valid, bus.in_ready} !== 2'b00) begin
            failed++;
            $display("FAIL nsrc2_fetch: got %b expected 00", {bus.out_valid, bus.in_ready});
        end
        step();
        tests++;
        if ({bus.out_valid, bus.out_op0, bus.out_op1, bus.out_op2, bus.out_tag} !== {1'b1, 8'h11, 8'h22, 8'h00, 8'h5A}) begin
            failed++;
            $display("FAIL nsrc2_bundle: got %h expected %h", {bus.out_valid, bus.out_op0, bus.out_op1, bus.out_op2, bus.out_tag}, {1'b1, 8'h11, 8'h22, 8'h00, 8'h5A});
        end
        step();
        tests++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            failed++;
            $display("FAIL nsrc2_idle: got %b expected 10", {bus.in_ready, bus.out_valid});
        end
    endtask
    task automatic test_nsrc3();
        issue(4'd0, 6'd1, 6'd2, 6'd3, 2'd3, 8'h3C);
        step();
        tests++;
        if (bus.out_valid !== 1'b0) begin
            failed++;
            $display("FAIL nsrc3_early: got %b expected 0", bus.out_valid);
        end
        step();
        tests++;
        if ({bus.out_valid, bus.out_op0, bus.out_op1, bus.out_op2, bus.out_tag} !== {1'b1, 8'h11, 8'h22, 8'h33, 8'h3C}) begin
            failed++;
            $display("FAIL nsrc3_bundle: got %h expected %h", {bus.out_valid, bus.out_op0, bus.out_op1, bus.out_op2, bus.out_tag}, {1'b1, 8'h11, 8'h22, 8'h33, 8'h3C});
        end
        step();
    endtask
    task automatic test_nsrc_low();
        issue(4'd0, 6'd2, 6'd1, 6'd3, 2'd1, 8'h61);
        tests++;
        if ({bus.rf_addr_a, bus.rf_addr_b} !== {10'd2, 10'd0}) begin
            failed++;
            $display("FAIL nsrc1_addrs: got %h expected %h", {bus.rf_addr_a, bus.rf_addr_b}, {10'd2, 10'd0});
        end
        step();
        tests++;
        if ({bus.out_valid, bus.out_op0, bus.out_op1, bus.out_op2, bus.out_tag} !== {1'b1, 8'h22, 8'h00, 8'h00, 8'h61}) begin
            failed++;
            $display("FAIL nsrc1_bundle: got %h expected %h", {bus.out_valid, bus.out_op0, bus.out_op1, bus.out_op2, bus.out_tag}, {1'b1, 8'h22, 8'h00, 8'h00, 8'h61});
        end
        step();
        issue(4'd0, 6'd1, 6'd2, 6'd3, 2'd0, 8'h77);
        tests++;
        if ({bus.out_valid, bus.out_op0, bus.out_op1, bus.out_op2, bus.out_tag} !== {1'b1, 8'h00, 8'h00, 8'h00, 8'h77}) begin
            failed++;
            $display("FAIL nsrc0_bundle: got %h expected %h", {bus.out_valid, bus.out_op0, bus.out_op1, bus.out_op2, bus.out_tag}, {1'b1, 8'h00, 8'h00, 8'h00, 8'h77});
        end
        step();
    endtask
    task automatic test_wb_stall();
        bus.wb_valid = 1'b1;
        bus.wb_addr = 10'd329;
        bus.wb_data = 8'h99;
        issue(4'd0, 6'd1, 6'd2, 6'd0, 2'd2, 8'h4B);
        tests++;
        if ({bus.out_valid, bus.rf_we_b, bus.rf_addr_b, bus.rf_addr_a} !== {1'b0, 1'b1, 10'd329, 10'd1}) begin
            failed++;
            $display("FAIL wb_fetch1: got %h expected %h", {bus.out_valid, bus.rf_we_b, bus.rf_addr_b, bus.rf_addr_a}, {1'b0, 1'b1, 10'd329, 10'd1});
        end
        step();
        tests++;
        if ({bus.out_valid, bus.rf_addr_a} !== {1'b0, 10'd2}) begin
            failed++;
            $display("FAIL wb_fetch2: got %h expected %h", {bus.out_valid, bus.rf_addr_a}, {1'b0, 10'd2});
        end
        step();
        tests++;
        if ({bus.out_valid, bus.out_op0, bus.out_op1, bus.out_op2, bus.out_tag} !== {1'b1, 8'h11, 8'h22, 8'h00, 8'h4B}) begin
            failed++;
            $display("FAIL wb_bundle: got %h expected %h", {bus.out_valid, bus.out_op0, bus.out_op1, bus.out_op2, bus.out_tag}, {1'b1, 8'h11, 8'h22, 8'h00, 8'h4B});
        end
        bus.wb_valid = 1'b0;
        step();
        issue(4'd5, 6'd9, 6'd0, 6'd0, 2'd1, 8'h95);
        step();
        tests++;
        if ({bus.out_valid, bus.out_op0} !== {1'b1, 8'h99}) begin
            failed++;
            $display("FAIL wb_landed: got %h expected %h", {bus.out_valid, bus.out_op0}, {1'b1, 8'h99});
        end
        step();
    endtask
    task automatic test_raw();
        bus.out_ready = 1'b0;
        issue(4'd2, 6'd5, 6'd0, 6'd0, 2'd1, 8'hA5);
        bus.wb_valid = 1'b1;
        bus.wb_addr = 10'd133;
        bus.wb_data = 8'hAB;
        step();
        bus.wb_valid = 1'b0;
        tests++;
        if ({bus.out_valid, bus.out_op0, bus.out_op1, bus.out_op2, bus.out_tag} !== {1'b1, 8'hAB, 8'h00, 8'h00, 8'hA5}) begin
            failed++;
            $display("FAIL raw_forward: got %h expected %h", {bus.out_valid, bus.out_op0, bus.out_op1, bus.out_op2, bus.out_tag}, {1'b1, 8'hAB, 8'h00, 8'h00, 8'hA5});
        end
        wb_write(10'd133, 8'hCD);
        tests++;
        if (bus.out_op0 !== 8'hAB) begin
            failed++;
            $display("FAIL raw_snapshot: got %h expected ab", bus.out_op0);
        end
    endtask
    task automatic test_backpressure();
        for (int i = 0; i < 4; i++) begin
            step();
            tests++;
            if ({bus.out_valid, bus.in_ready, bus.out_op0, bus.out_op1, bus.out_op2, bus.out_tag} !== {2'b10, 8'hAB, 8'h00, 8'h00, 8'hA5}) begin
                failed++;
                $display("FAIL hold_%0d: got %h expected %h", i, {bus.out_valid, bus.in_ready, bus.out_op0, bus.out_op1, bus.out_op2, bus.out_tag}, {2'b10, 8'hAB, 8'h00, 8'h00, 8'hA5});
            end
        end
        bus.out_ready = 1'b1;
        step();
        tests++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            failed++;
            $display("FAIL release_idle: got %b expected 10", {bus.in_ready, bus.out_valid});
        end
        issue(4'd2, 6'd5, 6'd0, 6'd0, 2'd1, 8'h01);
        step();
        tests++;
        if (bus.out_op0 !== 8'hCD) begin
            failed++;
            $display("FAIL wb_during_hold: got %h expected cd", bus.out_op0);
        end
        step();
    endtask
    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        issue(4'd0, 6'd1, 6'd2, 6'd3, 2'd3, 8'h99);
        step();
        bus.wb_valid = 1'b1;
        bus.wb_addr = 10'd7;
        bus.wb_data = 8'hEE;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({bus.out_valid, bus.out_op0, bus.out_op1, bus.out_op2, bus.out_tag, bus.rf_we_b} !== 34'h0) begin
            failed++;
            $display("FAIL reset_fetch: got %h expected 0", {bus.out_valid, bus.out_op0, bus.out_op1, bus.out_op2, bus.out_tag, bus.rf_we_b});
        end
        step();
        bus.wb_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        tests++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            failed++;
            $display("FAIL reset_fetch_idle: got %b expected 10", {bus.in_ready, bus.out_valid});
        end
        step();
        issue(4'd0, 6'd2, 6'd1, 6'd0, 2'd2, 8'h21);
        step();
        tests++;
        if ({bus.out_valid, bus.out_op0, bus.out_op1, bus.out_op2, bus.out_tag} !== {1'b1, 8'h22, 8'h11, 8'h00, 8'h21}) begin
            failed++;
            $display("FAIL after_reset_bundle: got %h expected %h", {bus.out_valid, bus.out_op0, bus.out_op1, bus.out_op2, bus.out_tag}, {1'b1, 8'h22, 8'h11, 8'h00, 8'h21});
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({bus.out_valid, bus.out_op0, bus.out_op1, bus.out_op2, bus.out_tag} !== 33'h0) begin
            failed++;
            $display("FAIL reset_out: got %h expected 0", {bus.out_valid, bus.out_op0, bus.out_op1, bus.out_op2, bus.out_tag});
        end
        step();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        step();
        issue(4'd0, 6'd7, 6'd3, 6'd0, 2'd2, 8'h31);
        step();
        tests++;
        if ({bus.out_valid, bus.out_op0, bus.out_op1, bus.out_op2, bus.out_tag} !== {1'b1, 8'h70, 8'h33, 8'h00, 8'h31}) begin
            failed++;
            $display("FAIL reset_blocked_wb: got %h expected %h", {bus.out_valid, bus.out_op0, bus.out_op1, bus.out_op2, bus.out_tag}, {1'b1, 8'h70, 8'h33, 8'h00, 8'h31});
        end
        step();
    endtask
    initial begin
        bus.in_valid = 1'b0;
        bus.in_warp = '0;
        bus.in_src0 = '0;
        bus.in_src1 = '0;
        bus.in_src2 = '0;
        bus.in_nsrc = '0;
        bus.in_tag = '0;
        bus.wb_valid = 1'b0;
        bus.wb_addr = '0;
        bus.wb_data = '0;
        bus.out_ready = 1'b1;
        test_reset();
        wb_write(10'd1, 8'h11);
        wb_write(10'd2, 8'h22);
        wb_write(10'd3, 8'h33);
        wb_write(10'd7, 8'h70);
        wb_write(10'd133, 8'h01);
        test_nsrc2();
        test_nsrc3();
        test_nsrc_low();
        test_wb_stall();
        test_raw();
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/operand_collector.md
# operand_collector

Operand-fetch stage that sits directly upstream of `dp_regfile` in the warp unit. It accepts one decoded instruction at a time, reads up to three source operands through the register file's two ports, and presents a complete operand bundle downstream with a valid/ready handshake. It also owns the register-file write path for writeback, which takes priority on port B.

## Interface
- `WARP_W`, 4: warp-id width.
- `REG_W`, 6: per-warp register index width. Register-file address is `{warp, reg}`, so `A_W = WARP_W+REG_W` (10) and every generated address is `< 2^A_W = RAM_SIZE`.
- `D_W`, 8: operand data width; equals register-file data width.
- `TAG_W`, 8: opaque instruction tag, passed through unchanged.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `in_valid` in 1: instruction offered.
- `in_ready` out 1: collector can accept an instruction.
- `in_warp` in WARP_W: warp id.
- `in_src0`, `in_src1`, `in_src2` in REG_W each: source register indices.
- `in_nsrc` in 2: number of sources used, 0–3; value 3 means src0..src2.
- `in_tag` in TAG_W: instruction tag.
- `wb_valid` in 1: writeback request; always accepted, no ready.
- `wb_addr` in A_W: writeback register-file address.
- `wb_data` in D_W: writeback data.
- `rf_addr_a`, `rf_addr_b` out A_W: register-file addresses.
- `rf_din_a`, `rf_din_b` out D_W: register-file write data. `rf_din_a` is tied to 0.
- `rf_we_a`, `rf_we_b` out 1: register-file write enables. `rf_we_a` is tied to 0.
- `rf_dout_a`, `rf_dout_b` in D_W: register-file combinational read data.
- `out_valid` out 1: operand bundle valid.
- `out_ready` in 1: consumer accepts the bundle.
- `out_op0`, `out_op1`, `out_op2` out D_W: operands. Unused operands are 0.
- `out_tag` out TAG_W: tag of the bundled instruction.

## Operation
- FSM states: IDLE, FETCH, OUT.
- IDLE:
  - `in_ready=1`.
  - On `in_valid`: latch warp, srcs and tag; set pending mask to the low `in_nsrc` bits; clear op0..op2 to 0.
  - Next state is FETCH if `in_nsrc>0`, otherwise OUT.
- FETCH (`in_ready=0`), each cycle:
  - Port A reads the lowest-index pending operand.
  - If `wb_valid=0`, port B reads the next pending operand.
  - Each read value is captured into its op register at the clock edge, and that pending bit is cleared.
  - When the mask becomes empty, go to OUT on the same edge.
- OUT:
  - `out_valid=1`; op/tag registers are held stable.
  - On `out_valid && out_ready`, go to IDLE.
- Writeback, in any state after reset:
  - `rf_we_b=wb_valid`, `rf_addr_b=wb_addr`, `rf_din_b=wb_data`.
  - Port B is unavailable for reads in that cycle.
  - If `wb_addr` equals the port-A read address, the register file forwards `din_b` to `dout_a`, so the new value is captured. This is the required RAW behaviour.
- Idle port addresses drive 0 with `rf_we_*=0`.
- Captured operands are snapshots. A writeback after capture does not update them.
- `in_src*` beyond `in_nsrc` are ignored. No read is issued for them.

## Timing
- Reset (`rst=0`), asynchronous:
  - State becomes IDLE and the pending mask clears.
  - `out_valid=0`; op0..op2=0; `out_tag=0`.
  - `rf_we_b` is forced to 0 while `rst=0`.
  - `in_ready` reads 1 once `rst` deasserts.
  - Reset mid-FETCH or mid-OUT drops the instruction.
- Accept edge N, `wb_valid` low:
  - `nsrc=1` or `2`: FETCH in cycle N+1, `out_valid` from N+2.
  - `nsrc=3`: FETCH in N+1 and N+2, `out_valid` from N+3.
  - `nsrc=0`: `out_valid` from N+1.
- Each cycle with `wb_valid=1` in FETCH limits progress to one operand, adding up to 1 cycle per such cycle.
- Back-pressure: `out_valid` stays high and data stays stable until `out_ready`.
- IDLE is re-entered one cycle after the handshake. Minimum initiation interval is 3 cycles for `nsrc` 1–2.

## Test plan
- Reset, then preload regs w0:r1=0x11, r2=0x22 via wb. Issue warp0, srcs(1,2), `nsrc=2`, tag 0x5A → `out_valid` 2 cycles after accept; ops=0x11,0x22,0x00; tag 0x5A.
- `nsrc=3` srcs(1,2,3), r3=0x33 → two FETCH cycles; op2=0x33; `out_valid` at N+3.
- `nsrc=2` with `wb_valid` held high to an unrelated address → one operand per cycle; `out_valid` at N+3; wb write lands.
- RAW: wb to w2:r5=0xAB in the same cycle port A reads w2:r5 → op0=0xAB.
- `out_ready` low for 4 cycles → `out_valid` and ops stable; `in_ready=0`. Release → IDLE next cycle, `in_ready=1`.
- Assert `rst` low mid-FETCH → `out_valid=0`, ops=0, `rf_we_b=0` immediately. After release, a new instruction is accepted normally.
